// File: rtl/eth_frame_pkg.sv
// Shared Ethernet framing constants, CRC-32 parameters and TX FSM state encoding.
package eth_frame_pkg;
  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam logic [31:0] CRC32_POLY_R    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE_R = 32'hDEBB20E3;

  localparam int HDR_BYTES      = 14;
  localparam int MIN_DATA_BYTES = 46;
  localparam int PKG_BYTES      = 16;
  localparam int PREAMBLE_BYTES = 8;
  localparam int FCS_BYTES      = 4;
  localparam int PAD_BYTES      = MIN_DATA_BYTES - PKG_BYTES;

  typedef enum logic [2:0] {
    TX_IDLE, TX_PREAMBLE, TX_HEADER, TX_PAYLOAD, TX_PAD, TX_FCS, TX_IPG
  } tx_state_t;
endpackage

// File: rtl/pkg_rmii_tx_framer_if.sv
// Package-side request and RMII-side dibit stream of the TX framer.
interface pkg_rmii_tx_framer_if;
  logic         tx_start;
  logic [127:0] tx_package_i;
  logic [1:0]   ctrl_tx_data;
  logic         ctrl_tx_en;
  logic         tx_busy;
  logic         tx_done;
  logic [7:0]   drop_cnt;

  modport master (
    output tx_start, tx_package_i,
    input  ctrl_tx_data, ctrl_tx_en, tx_busy, tx_done, drop_cnt
  );
  modport slave (
    input  tx_start, tx_package_i,
    output ctrl_tx_data, ctrl_tx_en, tx_busy, tx_done, drop_cnt
  );
endinterface

// File: rtl/pkg_rmii_tx_framer_crc32_d2.sv
// Combinational 2-bit-per-step reflected CRC-32 next-state; shared with the RX checker.
module crc32_d2
  import eth_frame_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [1:0]  data_i,
  output logic [31:0] crc_o
);
  always_comb begin
    crc_o = crc_i;
    // data_i[0] is the earlier bit on the wire
    for (int i = 0; i < 2; i++) begin
      crc_o = (crc_o >> 1) ^ ({32{crc_o[0] ^ data_i[i]}} & CRC32_POLY_R);
    end
  end
endmodule

// File: rtl/pkg_rmii_tx_framer.sv
// Frames a 16-byte control package as an Ethernet II frame on the RMII dibit stream.
module pkg_rmii_tx_framer
  import eth_frame_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter bit          PAD_EN    = 1'b1,
  parameter int          IPG_BYTES = 12   // must be >= 1
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  pkg_rmii_tx_framer_if.slave  bus
);
  localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};

  localparam logic [2:0] S_IDLE = 3'(TX_IDLE);
  localparam logic [2:0] S_PRE  = 3'(TX_PREAMBLE);
  localparam logic [2:0] S_HDR  = 3'(TX_HEADER);
  localparam logic [2:0] S_PAY  = 3'(TX_PAYLOAD);
  localparam logic [2:0] S_PAD  = 3'(TX_PAD);
  localparam logic [2:0] S_FCS  = 3'(TX_FCS);
  localparam logic [2:0] S_IPG  = 3'(TX_IPG);

  logic [2:0]   state_q, state_d;
  logic [7:0]   byte_q, byte_d;
  logic [1:0]   dib_q, dib_d;
  logic [127:0] pkg_q, pkg_d;
  logic [31:0]  crc_q, crc_d, crc_nxt;
  logic [31:0]  fcs_q, fcs_d, fcs_cur;
  logic [1:0]   data_q, data_d;
  logic         en_q, en_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]   drop_q, drop_d;
  logic [7:0]   cur_byte;
  logic [3:0]   hdr_idx;

  function automatic logic [7:0] last_byte(input logic [2:0] s);
    case (s)
      S_PRE:   last_byte = 8'(PREAMBLE_BYTES - 1);
      S_HDR:   last_byte = 8'(HDR_BYTES - 1);
      S_PAY:   last_byte = 8'(PKG_BYTES - 1);
      S_PAD:   last_byte = 8'(PAD_BYTES - 1);
      S_FCS:   last_byte = 8'(FCS_BYTES - 1);
      default: last_byte = 8'(IPG_BYTES - 1);
    endcase
  endfunction

  function automatic logic [2:0] next_state(input logic [2:0] s);
    case (s)
      S_PRE:   next_state = S_HDR;
      S_HDR:   next_state = S_PAY;
      S_PAY:   next_state = PAD_EN ? S_PAD : S_FCS;
      S_PAD:   next_state = S_FCS;
      S_FCS:   next_state = S_IPG;
      default: next_state = S_IDLE;
    endcase
  endfunction

  // data_q is the dibit on the wire this cycle, so the CRC trails it by one step
  crc32_d2 u_crc (.crc_i(crc_q), .data_i(data_q), .crc_o(crc_nxt));

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    dib_d   = dib_q;
    pkg_d   = pkg_q;
    drop_d  = drop_q;
    if (state_q == S_IDLE) begin
      if (bus.tx_start) begin
        state_d = S_PRE;
        byte_d  = '0;
        dib_d   = '0;
        pkg_d   = bus.tx_package_i;
      end
    end else begin
      if (bus.tx_start && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      dib_d = dib_q + 2'd1;
      if (dib_q == 2'd3) begin
        if (byte_q == last_byte(state_q)) begin
          byte_d  = '0;
          state_d = next_state(state_q);
        end else begin
          byte_d = byte_q + 8'd1;
        end
      end
    end
  end

  // Outputs are computed from the next position so the registers present it this cycle
  always_comb begin
    cur_byte = 8'h00;
    hdr_idx  = 4'(HDR_BYTES - 1) - byte_d[3:0];
    case (state_d)
      S_PRE:   cur_byte = (byte_d == 8'(PREAMBLE_BYTES - 1)) ? SFD_BYTE : PREAMBLE_BYTE;
      S_HDR:   cur_byte = HDR[{hdr_idx, 3'b000} +: 8];
      S_PAY:   cur_byte = pkg_q[{byte_d[3:0], 3'b000} +: 8];
      default: cur_byte = 8'h00;
    endcase

    fcs_cur = (state_q != S_FCS) ? ~crc_nxt : fcs_q;
    fcs_d   = fcs_q;
    en_d    = (state_d != S_IDLE) && (state_d != S_IPG);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_FCS) && (state_d == S_IPG);
    data_d  = 2'b00;
    if (state_d == S_FCS) begin
      data_d = fcs_cur[1:0];
      fcs_d  = fcs_cur >> 2;
    end else if (en_d) begin
      data_d = cur_byte[{dib_d, 1'b0} +: 2];
    end

    crc_d = crc_q;
    if (state_q == S_IDLE)
      crc_d = CRC32_INIT;
    else if (state_q == S_HDR || state_q == S_PAY || state_q == S_PAD)
      crc_d = crc_nxt;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      byte_q  <= '0;
      dib_q   <= '0;
      pkg_q   <= '0;
      crc_q   <= CRC32_INIT;
      fcs_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      dib_q   <= dib_d;
      pkg_q   <= pkg_d;
      crc_q   <= crc_d;
      fcs_q   <= fcs_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.ctrl_tx_data = data_q;
  assign bus.ctrl_tx_en   = en_q;
  assign bus.tx_busy      = busy_q;
  assign bus.tx_done      = done_q;
  assign bus.drop_cnt     = drop_q;
endmodule

// File: tb/tb_pkg_rmii_tx_framer.sv
// Scoreboard bench for pkg_rmii_tx_framer: padded and unpadded builds, one observed at a time.
module tb_pkg_rmii_tx_framer;
  localparam int IPG       = 12;
  localparam int LEN_PAD   = 288;
  localparam int LEN_NOPAD = 168;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  int e = 0;  // number of rising edges so far
  always @(posedge clk) e <= e + 1;

  logic         start_r = 1'b0;
  logic [127:0] pkg_r = '0;
  bit           sel = 1'b0;  // 0: padded DUT, 1: unpadded DUT

  pkg_rmii_tx_framer_if if0 ();
  pkg_rmii_tx_framer_if if1 ();
  assign if0.tx_start     = start_r & ~sel;
  assign if1.tx_start     = start_r & sel;
  assign if0.tx_package_i = pkg_r;
  assign if1.tx_package_i = pkg_r;

  pkg_rmii_tx_framer #(.PAD_EN(1'b1), .IPG_BYTES(IPG)) dut0 (.sys_clk(clk), .rst_n(rst_n), .bus(if0));
  pkg_rmii_tx_framer #(.PAD_EN(1'b0), .IPG_BYTES(IPG)) dut1 (.sys_clk(clk), .rst_n(rst_n), .bus(if1));

  logic [1:0] m_data;
  logic       m_en, m_busy, m_done;
  logic [7:0] m_drop;
  assign m_data = sel ? if1.ctrl_tx_data : if0.ctrl_tx_data;
  assign m_en   = sel ? if1.ctrl_tx_en   : if0.ctrl_tx_en;
  assign m_busy = sel ? if1.tx_busy      : if0.tx_busy;
  assign m_done = sel ? if1.tx_done      : if0.tx_done;
  assign m_drop = sel ? if1.drop_cnt     : if0.drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_dib [$];
  int         exp_rise [$];
  int         exp_done [$];
  int         last_n = -100000;
  int         exp_drop = 0;
  bit         abort = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      if (c[0] ^ v[i]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  task automatic push_frame(input logic [127:0] p, input bit pad);
    logic [7:0]   b [$];
    logic [111:0] hdr;
    logic [31:0]  c;
    hdr = {48'hFFFF_FFFF_FFFF, 48'h02_00_00_00_00_01, 16'h88B5};
    for (int k = 0; k < 7; k++) b.push_back(8'h55);
    b.push_back(8'hD5);
    for (int k = 0; k < 14; k++) b.push_back(hdr[111 - 8*k -: 8]);
    for (int k = 0; k < 16; k++) b.push_back(p[8*k +: 8]);
    if (pad) for (int k = 0; k < 30; k++) b.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    for (int k = 8; k < b.size(); k++) c = crc_bits(c, b[k], 8);
    c = ~c;
    for (int k = 0; k < 4; k++) b.push_back(c[8*k +: 8]);
    foreach (b[k]) for (int j = 0; j < 4; j++) exp_dib.push_back(b[k][2*j +: 2]);
  endtask

  function automatic int flen();
    return sel ? LEN_NOPAD : LEN_PAD;
  endfunction

  // Drive tx_start for exactly one rising edge and predict accept or drop
  task automatic tick_start(input logic [127:0] p);
    int edge_n;
    edge_n  = e + 1;
    start_r = 1'b1;
    pkg_r   = p;
    if (edge_n > last_n + flen() + 4*IPG) begin
      last_n = edge_n;
      exp_rise.push_back(edge_n + 1);
      exp_done.push_back(edge_n + flen() + 1);
      push_frame(p, !sel);
    end else if (exp_drop < 255) begin
      exp_drop++;
    end
    @(negedge clk);
    start_r = 1'b0;
  endtask

  task automatic to_edge(input int target);
    while (e + 1 < target) @(negedge clk);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  int         run = 0;
  logic [31:0] racc = 32'hFFFF_FFFF;
  logic        prev_en = 1'b0;

  always @(negedge clk) begin
    if (abort) begin
      if (!m_en) begin
        exp_dib.delete();
        exp_rise.delete();
        exp_done.delete();
        run = 0;
        racc = 32'hFFFF_FFFF;
        prev_en = 1'b0;
        abort = 1'b0;
      end
    end else if (rst_n) begin
      if (m_en) begin
        if (!prev_en) begin
          chk("rise_expected", 32'(exp_rise.size() > 0), 1);
          if (exp_rise.size() > 0) chk("rise_cycle", e + 1, exp_rise.pop_front());
        end
        chk("dib_expected", 32'(exp_dib.size() > 0), 1);
        if (exp_dib.size() > 0) chk($sformatf("dibit[%0d]", run), 32'(m_data), 32'(exp_dib.pop_front()));
        if (run >= 32) racc = crc_bits(racc, {6'b0, m_data}, 2);
        run++;
      end else begin
        chk("idle_data", 32'(m_data), 0);
        if (prev_en) begin
          chk("frame_len", run, flen());
          chk("fcs_residue", racc, 32'hDEBB20E3);
          run = 0;
          racc = 32'hFFFF_FFFF;
        end
      end
      if (m_done) begin
        chk("done_expected", 32'(exp_done.size() > 0), 1);
        if (exp_done.size() > 0) chk("done_cycle", e + 1, exp_done.pop_front());
      end
      prev_en = m_en;
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_en",   32'(if0.ctrl_tx_en),   0);
    chk("rst_data", 32'(if0.ctrl_tx_data), 0);
    chk("rst_busy", 32'(if0.tx_busy),      0);
    chk("rst_done", 32'(if0.tx_done),      0);
    chk("rst_drop", 32'(if0.drop_cnt),     0);
    chk("rst_en1",  32'(if1.ctrl_tx_en),   0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Known frame; package changes right after the latch edge; drops mid-frame and at IPG end
    n = e + 1;
    tick_start(128'h0F0E0D0C0B0A09080706050403020100);
    pkg_r = '1;
    chk("busy_first", 32'(m_busy), 1);
    to_edge(n + 10);  tick_start(rnd128());
    to_edge(n + 200); tick_start(rnd128());
    chk("drop_two", 32'(m_drop), 2);
    to_edge(n + 336);
    chk("busy_ipg_end", 32'(m_busy), 1);
    tick_start(rnd128());
    chk("busy_released", 32'(m_busy), 0);
    chk("drop_three", 32'(m_drop), 3);
    tick_start(rnd128());  // edge n+337: accepted
    chk("restart_edge", last_n, n + 337);

    for (int i = 0; i < 100; i++) begin
      to_edge(last_n + LEN_PAD + 4*IPG + 1);
      tick_start(rnd128());
    end

    // Hold tx_start high through most of a frame to saturate the drop counter
    to_edge(last_n + LEN_PAD + 4*IPG + 1);
    tick_start(rnd128());
    for (int i = 0; i < 270; i++) tick_start(rnd128());
    chk("drop_sat", 32'(m_drop), 255);

    // Mid-frame reset aborts without tx_done; next frame is complete
    to_edge(last_n + LEN_PAD + 4*IPG + 1);
    n = e + 1;
    tick_start(rnd128());
    to_edge(n + 100);
    abort = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_drop = 0;
    last_n = -100000;
    chk("abort_en",   32'(m_en),   0);
    chk("abort_busy", 32'(m_busy), 0);
    chk("abort_drop", 32'(m_drop), 0);
    repeat (400) @(negedge clk);
    tick_start(rnd128());
    to_edge(last_n + LEN_PAD + 4*IPG + 1);

    // Unpadded build
    sel = 1'b1;
    @(negedge clk);
    tick_start(128'h0F0E0D0C0B0A09080706050403020100);
    for (int i = 0; i < 4; i++) begin
      to_edge(last_n + LEN_NOPAD + 4*IPG + 1);
      tick_start(rnd128());
    end
    to_edge(last_n + LEN_NOPAD + 4*IPG + 5);
    chk("nopad_drop", 32'(m_drop), exp_drop);
    chk("dib_drained",  exp_dib.size(),  0);
    chk("rise_drained", exp_rise.size(), 0);
    chk("done_drained", exp_done.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
